amber48_uart_rx: RTL and testbench
==================================

AMBER48_UART_RX -- requirements
Module: amber48_uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ_HZ, default 27_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, >= 2.
REQ-004 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port rx_i  input  1  raw asynchronous serial line; idle high.
REQ-007 SHALL have port data_o  output  8  received byte at FIFO head.
REQ-008 SHALL have port valid_o  output  1  data_o holds a valid byte.
REQ-009 SHALL have port ready_i  input  1  consumer accepts data_o this cycle.
REQ-010 SHALL have port frame_err_o  output  1  one-cycle pulse when a stop bit samples low.
REQ-011 SHALL have port overrun_o  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port busy_o  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL define BIT_CYCLES = CLOCK_FREQ_HZ / BAUD_RATE (integer division) and HALF_CYCLES = BIT_CYCLES / 2; BIT_CYCLES < 4 is a compile-time error.
REQ-014 SHALL pass rx_i through a two-flop synchronizer, both flops resetting to 1; all FSM decisions use the second flop (rx_s).
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: when rx_s == 0, SHALL go to START and load the bit counter for HALF_CYCLES.
REQ-017 START: when the counter expires, rx_s == 0 SHALL go to DATA with bit index 0; rx_s == 1 SHALL return to IDLE with no output (glitch reject).
REQ-018 DATA: SHALL sample rx_s every BIT_CYCLES into bit[index], LSB first; after bit 7 is sampled SHALL go to STOP.
REQ-019 STOP: after BIT_CYCLES SHALL sample rx_s; 1 pushes the byte and goes to IDLE; 0 pulses frame_err_o, discards the byte and goes to BREAK.
REQ-020 BREAK: SHALL remain until rx_s == 1, then go to IDLE; no start detection while in BREAK.
REQ-021 FIFO SHALL be first-word-fall-through: valid_o = not empty; data_o = head entry; pop when valid_o && ready_i.
REQ-022 A push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle; otherwise the byte is dropped and overrun_o pulses.
REQ-023 Simultaneous push and pop on a non-empty FIFO SHALL leave the occupancy unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-024 Latency: valid_o SHALL rise on the cycle after the stop-bit sample edge when the FIFO was empty.
REQ-025 ready_i while valid_o == 0 SHALL have no effect.
REQ-026 data_o when valid_o == 0 is don't-care; the bench SHALL NOT check it.
REQ-027 frame_err_o and overrun_o SHALL never be high in the same cycle.

Reset
REQ-028 Asserting rst_ni low SHALL, at any time including mid-frame, force: FSM IDLE; counters 0; synchronizer flops 1; FIFO empty; valid_o = 0; frame_err_o = 0; overrun_o = 0; busy_o = 0; data_o = 8'h00.
REQ-029 After rst_ni deasserts, a line already low SHALL be treated as a start edge only once rx_s reads 0, i.e. after the synchronizer latency.

Verification (bench params CLOCK_FREQ_HZ=1_000_000, BAUD_RATE=100_000 -> BIT_CYCLES=10, HALF_CYCLES=5)
REQ-030 SHALL cover: frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), ready_i = 1 -> exactly one valid_o cycle with data_o = 8'hA5; frame_err_o and overrun_o stay 0.
REQ-031 SHALL cover: rx_i low for 3 cycles, then high -> FSM returns to IDLE; valid_o never asserts; busy_o falls within HALF_CYCLES + 3 cycles.
REQ-032 SHALL cover: frame 0x3C with the stop bit held low for 30 cycles -> one frame_err_o pulse; no push; busy_o stays high until the line returns high.
REQ-033 SHALL cover: ready_i = 0 and 5 frames 0x01..0x05 -> overrun_o pulses once, on the 5th frame; draining yields 0x01, 0x02, 0x03, 0x04 in order.
REQ-034 SHALL cover: FIFO full, ready_i = 1 in the stop-sample cycle of a 0x77 frame -> no overrun; after drain the last byte read is 0x77.
REQ-035 SHALL cover: rst_ni pulsed low mid DATA of frame 0xFF -> all outputs reach their reset values immediately; the next clean frame 0x42 is received correctly.

Source files
------------

// File: rtl/amber48_uart_rx.sv
// amber48_uart_rx: 8N1 UART receiver with a two-flop line synchronizer, a
// mid-bit sampling FSM and a first-word-fall-through receive FIFO.
module amber48_uart_rx #(
  parameter int CLOCK_FREQ_HZ = 27_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int BIT_CYCLES  = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int OCC_W       = PTR_W + 1;

  if (BIT_CYCLES < 4) begin : g_bit_cycles_check
    $error("amber48_uart_rx: CLOCK_FREQ_HZ / BAUD_RATE must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth_check
    $error("amber48_uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  state_e             state_r;
  logic               sync1_r;
  logic               rx_s_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [2:0]         bit_idx_r;
  logic [7:0]         shift_r;
  logic               busy_r;
  logic               frame_err_r;

  logic [7:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [OCC_W-1:0]   occ_r;
  logic               valid_r;
  logic               overrun_r;

  logic               tick_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               accept_s;
  logic [OCC_W-1:0]   occ_next_s;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_r <= 1'b1;
      rx_s_r  <= 1'b1;
    end else begin
      sync1_r <= rx_i;
      rx_s_r  <= sync1_r;
    end
  end

  // Bit-timer expiry, completed-frame push and FIFO handshake decode.
  always_comb begin
    tick_s   = (bit_cnt_r == CNT_W'(1));
    push_s   = (state_r == ST_STOP) && tick_s && rx_s_r;
    pop_s    = valid_r && ready_i;
    full_s   = (occ_r == OCC_W'(FIFO_DEPTH));
    accept_s = push_s && (!full_s || pop_s);
  end

  // Next FIFO occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    occ_next_s = occ_r;
    case ({accept_s, pop_s})
      2'b10:   occ_next_s = occ_r + OCC_W'(1);
      2'b01:   occ_next_s = occ_r - OCC_W'(1);
      default: occ_next_s = occ_r;
    endcase
  end

  // Receive FSM: half-bit start qualification, then full-bit sampling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!rx_s_r) begin
            state_r   <= ST_START;
            bit_cnt_r <= CNT_W'(HALF_CYCLES);
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (!rx_s_r) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= CNT_W'(BIT_CYCLES);
              bit_idx_r <= 3'd0;
            end else begin
              state_r   <= ST_IDLE;
              bit_cnt_r <= '0;
              busy_r    <= 1'b0;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            shift_r   <= {rx_s_r, shift_r[7:1]};
            bit_cnt_r <= CNT_W'(BIT_CYCLES);
            if (bit_idx_r == 3'd7) begin
              state_r   <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            bit_cnt_r <= '0;
            if (rx_s_r) begin
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
            end else begin
              state_r     <= ST_BREAK;
              frame_err_r <= 1'b1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
          end
        end
        ST_BREAK: begin
          // A held-low line must go high again before a new start can be seen.
          if (rx_s_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_BREAK;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= '0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Receive FIFO storage, pointers, occupancy and overrun pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      occ_r     <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= push_s && !accept_s;
      if (accept_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      occ_r   <= occ_next_s;
      valid_r <= (occ_next_s != '0);
    end
  end

  assign data_o      = mem_r[rd_ptr_r];
  assign valid_o     = valid_r;
  assign frame_err_o = frame_err_r;
  assign overrun_o   = overrun_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_amber48_uart_rx.sv
// Self-checking bench for amber48_uart_rx: directed frames plus random traffic,
// compared every cycle against a timestamp-based receiver model and a queue FIFO.
module tb_amber48_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 4;
  localparam int BITC   = CLK_HZ / BAUD;
  localparam int HALFC  = BITC / 2;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;
  int ready_mode = 1;

  // model state
  bit         s1, s2, rxs, in_break, m_ferr_p, m_ovr_p, m_push, m_pop;
  int         t_frame = -1;
  int         k;
  logic [7:0] m_sh, m_last_push;
  logic [7:0] mq[$];
  int         m_push_cnt = 0, m_ferr_cnt = 0, m_ovr_cnt = 0;

  // DUT observations
  bit         prev_valid = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] dut_pops[$];
  int         dut_valid_cycles = 0, dut_ferr_cnt = 0, dut_ovr_cnt = 0;

  amber48_uart_rx #(
    .CLOCK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .rx_i(rx_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready: forced low, forced high or random, applied just after each falling edge.
  initial begin
    ready_i = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b0;
        1:       ready_i = 1'b1;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Model: frame offsets counted from the cycle the synchronized line is first seen low.
  always @(posedge clk) begin
    if (!rst_ni) begin
      s1 = 1'b1; s2 = 1'b1; t_frame = -1; in_break = 1'b0;
      m_ferr_p = 1'b0; m_ovr_p = 1'b0;
      mq.delete();
    end else begin
      rxs = s2; s2 = s1; s1 = rx_i;
      m_ferr_p = 1'b0; m_ovr_p = 1'b0; m_push = 1'b0;
      m_pop = (mq.size() > 0) && ready_i;
      if (prev_valid && ready_i) dut_pops.push_back(prev_data);
      if (in_break) begin
        if (rxs) in_break = 1'b0;
      end else if (t_frame < 0) begin
        if (!rxs) t_frame = 0;
      end else begin
        t_frame++;
        if (t_frame == HALFC) begin
          if (rxs) t_frame = -1;
        end else if (t_frame > HALFC && (t_frame - HALFC) % BITC == 0) begin
          k = (t_frame - HALFC) / BITC - 1;
          if (k < 8) begin
            m_sh[k] = rxs;
          end else begin
            t_frame = -1;
            if (rxs) m_push = 1'b1;
            else begin m_ferr_p = 1'b1; in_break = 1'b1; m_ferr_cnt++; end
          end
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(m_sh); m_last_push = m_sh; m_push_cnt++;
        end else begin
          m_ovr_p = 1'b1; m_ovr_cnt++;
        end
      end
    end
    #1;
    chk("valid", 32'(valid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("data", 32'(data_o), 32'(mq[0]));
    chk("frame_err", 32'(frame_err_o), 32'(m_ferr_p));
    chk("overrun", 32'(overrun_o), 32'(m_ovr_p));
    chk("busy", 32'(busy_o), 32'((t_frame >= 0) || in_break));
    chk("ferr_ovr_excl", 32'(frame_err_o & overrun_o), 32'd0);
    prev_valid = valid_o;
    prev_data  = data_o;
    if (valid_o) dut_valid_cycles++;
    if (frame_err_o) dut_ferr_cnt++;
    if (overrun_o) dut_ovr_cnt++;
  end

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // stop_low > 0 holds the stop bit low and returns with the line still low.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input bit pulse_ready);
    rx_i = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BITC) @(negedge clk);
    end
    if (stop_low > 0) begin
      rx_i = 1'b0;
      repeat (stop_low) @(negedge clk);
    end else begin
      rx_i = 1'b1;
      for (int c = 0; c < BITC; c++) begin
        if (pulse_ready) ready_mode = (c == 7) ? 1 : 0;
        @(negedge clk);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err_o), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun_o), 32'd0);
    chk({tag, "_data"}, 32'(data_o), 32'h00);
  endtask

  initial begin
    int v0, f0, o0, p0, mf0, mo0, waited;
    logic [7:0] b;
    rx_i = 1'b1; rst_ni = 1'b0; ready_mode = 1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk); rst_ni = 1'b1;
    idle(5);

    // clean 0xA5 frame
    v0 = dut_valid_cycles; f0 = dut_ferr_cnt; o0 = dut_ovr_cnt; p0 = dut_pops.size();
    send_frame(8'hA5, 0, 1'b0);
    idle(20);
    chk("a5_valid_cycles", 32'(dut_valid_cycles - v0), 32'd1);
    chk("a5_pops", 32'(dut_pops.size() - p0), 32'd1);
    if (dut_pops.size() > p0) chk("a5_data", 32'(dut_pops[p0]), 32'hA5);
    chk("a5_model", 32'(m_last_push), 32'hA5);
    chk("a5_ferr", 32'(dut_ferr_cnt - f0), 32'd0);
    chk("a5_ovr", 32'(dut_ovr_cnt - o0), 32'd0);

    // 3-cycle glitch is rejected
    v0 = dut_valid_cycles;
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    chk("glitch_busy_rise", 32'(busy_o), 32'd1);
    waited = 0;
    while (busy_o && waited < HALFC + 3) begin
      @(negedge clk);
      waited++;
    end
    chk("glitch_busy_fall", 32'(busy_o), 32'd0);
    idle(10);
    chk("glitch_no_valid", 32'(dut_valid_cycles - v0), 32'd0);

    // 0x3C with stop held low for 30 cycles
    v0 = dut_valid_cycles; f0 = dut_ferr_cnt; mf0 = m_ferr_cnt;
    send_frame(8'h3C, 30, 1'b0);
    chk("break_busy_held", 32'(busy_o), 32'd1);
    idle(15);
    chk("break_busy_released", 32'(busy_o), 32'd0);
    chk("ferr_count", 32'(dut_ferr_cnt - f0), 32'd1);
    chk("ferr_model", 32'(m_ferr_cnt - mf0), 32'd1);
    chk("ferr_no_push", 32'(dut_valid_cycles - v0), 32'd0);

    // five frames into a stalled four-entry FIFO
    ready_mode = 0;
    o0 = dut_ovr_cnt; mo0 = m_ovr_cnt; p0 = dut_pops.size();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 0, 1'b0);
      if (i == 4) chk("ovr_before_5th", 32'(dut_ovr_cnt - o0), 32'd0);
    end
    chk("ovr_after_5th", 32'(dut_ovr_cnt - o0), 32'd1);
    chk("ovr_model", 32'(m_ovr_cnt - mo0), 32'd1);
    ready_mode = 1;
    idle(10);
    chk("drain_count", 32'(dut_pops.size() - p0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (dut_pops.size() > p0 + i) chk("drain_order", 32'(dut_pops[p0 + i]), 32'(i + 1));
    end

    // full FIFO, pop coincides with the 0x77 stop sample
    ready_mode = 0;
    idle(2);
    o0 = dut_ovr_cnt; p0 = dut_pops.size();
    send_frame(8'h11, 0, 1'b0);
    send_frame(8'h22, 0, 1'b0);
    send_frame(8'h33, 0, 1'b0);
    send_frame(8'h44, 0, 1'b0);
    send_frame(8'h77, 0, 1'b1);
    chk("full_pop_no_ovr", 32'(dut_ovr_cnt - o0), 32'd0);
    ready_mode = 1;
    idle(10);
    chk("full_pop_count", 32'(dut_pops.size() - p0), 32'd5);
    if (dut_pops.size() > 0) chk("full_pop_last", 32'(dut_pops[dut_pops.size() - 1]), 32'h77);

    // reset in the middle of a 0xFF frame
    rx_i = 1'b0;
    repeat (BITC) @(negedge clk);
    rx_i = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    chk("midframe_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    idle(5);
    p0 = dut_pops.size();
    send_frame(8'h42, 0, 1'b0);
    idle(10);
    chk("post_rst_count", 32'(dut_pops.size() - p0), 32'd1);
    if (dut_pops.size() > p0) chk("post_rst_data", 32'(dut_pops[p0]), 32'h42);

    // random traffic, random consumer
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 9))
        0: begin
          rx_i = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge clk);
          idle($urandom_range(6, 12));
        end
        1: begin
          send_frame(b, $urandom_range(10, 25), 1'b0);
          idle($urandom_range(3, 12));
        end
        default: begin
          send_frame(b, 0, 1'b0);
          idle($urandom_range(0, 6));
        end
      endcase
    end
    ready_mode = 1;
    idle(40);
    chk("final_empty", 32'(valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
